bcd2bin_seq: RTL and testbench

- Sequential BCD-to-binary converter; the inverse of the existing binary-to-BCD block.
- Takes DIGITS packed BCD digits, for example a score or setting entered or stored as decimal digits.
- Produces an unsigned binary value using reverse double-dabble: shift right one bit per cycle, then apply a subtract-3 correction to each digit.
- Sits between the score/settings logic and any arithmetic or compare logic that needs plain binary; uses a start/done handshake.

---
 rtl/bcd2bin_seq_pkg.sv | 23 ++
 rtl/bcd2bin_seq_if.sv | 40 ++++
 rtl/bcd2bin_seq_bcd_digit_adj.sv | 18 +
 rtl/bcd2bin_seq.sv | 106 ++++++++++
 tb/tb_bcd2bin_seq.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// bcd2bin_seq_pkg
//   Shared constants and types for the sequential BCD-to-binary converter.
//   - state_t        : two-state FSM encoding (IDLE, SHIFT)
//   - BCD_MAX_DIGIT  : largest legal BCD digit value
//   - BCD_ADJ        : correction subtracted from a digit field
//   - BCD_THRESH     : digit value at or above which the correction applies
//   - nibble_bad()   : true when a 4-bit field is not a legal BCD digit
package bcd2bin_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_ADJ       = 4'd3;
  localparam logic [3:0] BCD_THRESH    = 4'd8;

  function automatic logic nibble_bad(input logic [3:0] nib);
    return (nib > BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if
//   Start/done handshake bundle between a requester and bcd2bin_seq.
//   - start   : one-cycle conversion request (requester -> converter)
//   - bcd_in  : packed BCD digits, [3:0] is the least significant digit
//   - busy    : conversion in progress
//   - done    : one-cycle completion pulse
//   - bin_out : binary result, held until the next done
//   - invalid : input contained a nibble greater than 9, held with bin_out
//   Modports: master (requester side), slave (converter side).
interface bcd2bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  invalid;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  invalid
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output invalid
  );

endinterface

// File: rtl/bcd2bin_seq_bcd_digit_adj.sv
// bcd_digit_adj
//   Combinational per-digit correction for reverse double-dabble.
//   After a right shift, a digit field that reads 8 or more had a 1 shifted
//   in from the digit above, worth 8 here but only 5 in decimal; subtracting
//   3 restores the decimal weight. The subtraction never borrows because the
//   field is already >= 8.
//   - din  : 4-bit digit field after the shift
//   - dout : corrected digit field
module bcd_digit_adj
  import bcd2bin_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_THRESH) ? (din - BCD_ADJ) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq
//   Sequential BCD-to-binary converter using reverse double-dabble. One
//   bit is shifted out of the BCD field into the binary field per cycle, and
//   every BCD digit is corrected in parallel in the same cycle. A conversion
//   always takes BIN_W cycles, including for invalid input.
//   - clk : system clock
//   - rst : synchronous active-high reset, aborts any conversion
//   - bus : start/bcd_in in, busy/done/bin_out/invalid out (all registered)
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic            clk,
  input  logic            rst,
  bcd2bin_seq_if.slave    bus
);

  localparam int SH_W  = 4 * DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state_reg;
  logic [SH_W-1:0]    shreg_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               err_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic               invalid_reg;

  logic [SH_W-1:0]    shifted;
  logic [SH_W-1:0]    shreg_next;
  logic [DIGITS-1:0]  nib_bad;
  logic               in_err;

  // Legality check of the incoming digits, captured on the accepting edge.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign nib_bad[gi] = nibble_bad(bus.bcd_in[4*gi +: 4]);
    end
  endgenerate

  assign in_err = |nib_bad;

  // One datapath step: logical right shift, then per-digit correction on the
  // BCD part. The binary part below it just receives the shifted bits.
  assign shifted = shreg_reg >> 1;
  assign shreg_next[BIN_W-1:0] = shifted[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (shifted[BIN_W + 4*gi +: 4]),
        .dout (shreg_next[BIN_W + 4*gi +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      bin_reg     <= '0;
      invalid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            shreg_reg <= {bus.bcd_in, {BIN_W{1'b0}}};
            err_reg   <= in_err;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_reg <= shreg_next;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // Invalid input still runs the full length so timing is constant;
            // only the published result is forced to zero.
            bin_reg     <= err_reg ? '0 : shreg_next[BIN_W-1:0];
            invalid_reg <= err_reg;
            done_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.bin_out = bin_reg;
  assign bus.invalid = invalid_reg;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq
//   Directed bench for bcd2bin_seq with hand-computed expected results.
module tb_bcd2bin_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd2bin_seq_if #(.DIGITS(2), .BIN_W(7)) bus ();

  bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start pulse launched at a falling edge; returns at the falling edge of
  // the cycle right after the accepting rising edge.
  task automatic pulse_start(input logic [7:0] bcd);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Counts cycles from the first cycle after acceptance (n=1) until done.
  // busy_all reports whether busy was high in every cycle before done and
  // hold_ok whether bin_out stayed at its entry value until done.
  task automatic wait_done(output int n, output bit busy_all, output bit hold_ok);
    logic [6:0] entry;
    entry    = bus.bin_out;
    n        = 1;
    busy_all = 1'b1;
    hold_ok  = 1'b1;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy !== 1'b1) busy_all = 1'b0;
      if (bus.bin_out !== entry) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.bin_out !== 7'd0) begin errors++; $display("FAIL reset_bin got=%0d exp=0", bus.bin_out); end
    checks++; if (bus.invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b exp=0", bus.invalid); end
    rst = 1'b0;
    $display("reset: busy=%b done=%b bin=%0d invalid=%b", bus.busy, bus.done, bus.bin_out, bus.invalid);
  endtask

  task automatic test_convert_42();
    int n; bit ba; bit ho;
    pulse_start(8'h42);
    wait_done(n, ba, ho);
    checks++; if (n !== 8) begin errors++; $display("FAIL c42_latency got=%0d exp=8", n); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL c42_busy_window got=%b exp=1", ba); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL c42_busy_at_done got=%b exp=0", bus.busy); end
    checks++; if (bus.bin_out !== 7'd42) begin errors++; $display("FAIL c42_bin got=%0d exp=42", bus.bin_out); end
    checks++; if (bus.invalid !== 1'b0) begin errors++; $display("FAIL c42_invalid got=%b exp=0", bus.invalid); end
    $display("convert 0x42: latency=%0d bin=%0d invalid=%b", n, bus.bin_out, bus.invalid);
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL c42_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.bin_out !== 7'd42) begin errors++; $display("FAIL c42_bin_hold got=%0d exp=42", bus.bin_out); end
  endtask

  task automatic test_full_and_zero();
    int n; bit ba; bit ho;
    pulse_start(8'h99);
    wait_done(n, ba, ho);
    checks++; if (n !== 8) begin errors++; $display("FAIL c99_latency got=%0d exp=8", n); end
    checks++; if (bus.bin_out !== 7'd99) begin errors++; $display("FAIL c99_bin got=%0d exp=99", bus.bin_out); end
    checks++; if (bus.invalid !== 1'b0) begin errors++; $display("FAIL c99_invalid got=%b exp=0", bus.invalid); end
    $display("convert 0x99: latency=%0d bin=%0d invalid=%b", n, bus.bin_out, bus.invalid);
    pulse_start(8'h00);
    wait_done(n, ba, ho);
    checks++; if (n !== 8) begin errors++; $display("FAIL c00_latency got=%0d exp=8", n); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL c00_busy_window got=%b exp=1", ba); end
    checks++; if (bus.bin_out !== 7'd0) begin errors++; $display("FAIL c00_bin got=%0d exp=0", bus.bin_out); end
    $display("convert 0x00: latency=%0d bin=%0d invalid=%b", n, bus.bin_out, bus.invalid);
  endtask

  task automatic test_invalid();
    int n; bit ba; bit ho;
    pulse_start(8'h3A);
    wait_done(n, ba, ho);
    checks++; if (n !== 8) begin errors++; $display("FAIL c3a_latency got=%0d exp=8", n); end
    checks++; if (bus.invalid !== 1'b1) begin errors++; $display("FAIL c3a_invalid got=%b exp=1", bus.invalid); end
    checks++; if (bus.bin_out !== 7'd0) begin errors++; $display("FAIL c3a_bin got=%0d exp=0", bus.bin_out); end
    $display("convert 0x3A: latency=%0d bin=%0d invalid=%b", n, bus.bin_out, bus.invalid);
    pulse_start(8'h15);
    wait_done(n, ba, ho);
    checks++; if (bus.invalid !== 1'b0) begin errors++; $display("FAIL c15_invalid got=%b exp=0", bus.invalid); end
    checks++; if (bus.bin_out !== 7'd15) begin errors++; $display("FAIL c15_bin got=%0d exp=15", bus.bin_out); end
    $display("convert 0x15: latency=%0d bin=%0d invalid=%b", n, bus.bin_out, bus.invalid);
  endtask

  task automatic test_ignore_busy();
    int n; int dones; int busy_cycles;
    pulse_start(8'h27);          // now in cycle k+1
    @(negedge clk);              // cycle k+2
    bus.start  = 1'b1;           // sampled at edge k+3 while busy
    bus.bcd_in = 8'h81;
    @(negedge clk);
    bus.start  = 1'b0;
    n = 3; dones = 0; busy_cycles = 2;
    while (n < 25) begin
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) begin
        checks++; if (bus.bin_out !== 7'd27) begin errors++; $display("FAIL ign_bin got=%0d exp=27", bus.bin_out); end
      end
      @(negedge clk);
      n++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    checks++; if (busy_cycles !== 7) begin errors++; $display("FAIL ign_busy_cycles got=%0d exp=7", busy_cycles); end
    $display("ignore while busy: dones=%0d busy_cycles=%0d bin=%0d", dones, busy_cycles, bus.bin_out);
  endtask

  task automatic test_back_to_back();
    int n; bit ba; bit ho;
    pulse_start(8'h10);
    wait_done(n, ba, ho);
    checks++; if (bus.bin_out !== 7'd10) begin errors++; $display("FAIL b2b_first_bin got=%0d exp=10", bus.bin_out); end
    $display("back-to-back first: latency=%0d bin=%0d", n, bus.bin_out);
    // Still inside the done cycle: this start is accepted immediately.
    bus.start  = 1'b1;
    bus.bcd_in = 8'h64;
    @(negedge clk);
    bus.start  = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    wait_done(n, ba, ho);
    checks++; if (n !== 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", n); end
    checks++; if (ho !== 1'b1) begin errors++; $display("FAIL b2b_hold got=%b exp=1", ho); end
    checks++; if (bus.bin_out !== 7'd64) begin errors++; $display("FAIL b2b_second_bin got=%0d exp=64", bus.bin_out); end
    $display("back-to-back second: latency=%0d bin=%0d", n, bus.bin_out);
  endtask

  task automatic test_reset_mid();
    int n; bit ba; bit ho; int dones;
    pulse_start(8'h55);          // cycle k+1
    @(negedge clk);              // cycle k+2
    @(negedge clk);              // cycle k+3
    rst = 1'b1;                  // sampled at edge k+4
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
    checks++; if (bus.bin_out !== 7'd0) begin errors++; $display("FAIL rmid_bin got=%0d exp=0", bus.bin_out); end
    checks++; if (bus.invalid !== 1'b0) begin errors++; $display("FAIL rmid_invalid got=%b exp=0", bus.invalid); end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", dones); end
    $display("reset mid-conversion: busy=%b bin=%0d stray=%0d", bus.busy, bus.bin_out, dones);
    pulse_start(8'h07);
    wait_done(n, ba, ho);
    checks++; if (bus.bin_out !== 7'd7) begin errors++; $display("FAIL rmid_after_bin got=%0d exp=7", bus.bin_out); end
    $display("convert 0x07 after reset: latency=%0d bin=%0d", n, bus.bin_out);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_convert_42();
    test_full_and_zero();
    test_invalid();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
